// File: rtl/opt_readout_scanner.sv
`timescale 1ns/1ps
// opt_readout_scanner: steps the detector mux over NUM_CH channels and averages 2^LOG2_SAMP ADC samples per channel.
// Optional feature macro THRESH_FLAG_EN adds a thresh input and a res_hit flag (res_data >= thresh).
module opt_readout_scanner #(
    parameter int NUM_CH     = 8,
    parameter int DATA_W     = 12,
    parameter int LOG2_SAMP  = 2,
    parameter int SETTLE_CYC = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic [$clog2(NUM_CH)-1:0] ch_sel,
    output logic                      adc_req,
    input  logic                      adc_valid,
    input  logic [DATA_W-1:0]         adc_data,
`ifdef THRESH_FLAG_EN
    input  logic [DATA_W-1:0]         thresh,
    output logic                      res_hit,
`endif
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [$clog2(NUM_CH)-1:0] res_ch,
    output logic [DATA_W-1:0]         res_data
);

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int ACC_W = DATA_W + LOG2_SAMP;
    localparam int SC_W  = LOG2_SAMP + 1;
    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [SC_W-1:0]  LAST_SAMP   = SC_W'((1 << LOG2_SAMP) - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CH_W-1:0]  LAST_CH     = CH_W'(NUM_CH - 1);

    typedef enum logic [2:0] {IDLE, SETTLE, REQ, WAIT, EMIT, FIN} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  settle_cnt;
    logic [SC_W-1:0]   samp_cnt;
    logic [ACC_W-1:0]  acc_p0;
    logic [ACC_W-1:0]  acc_sum_p0;
    logic [DATA_W-1:0] avg_p0;
    logic [DATA_W-1:0] res_data_p1;
    logic [CH_W-1:0]   res_ch_p1;
    logic              load_settle, clr_acc, add_samp, latch_res, ch_inc, ch_clr;

    function automatic logic [DATA_W-1:0] avg_trunc(input logic [ACC_W-1:0] sum);
        avg_trunc = DATA_W'(sum >> LOG2_SAMP);
    endfunction

    assign acc_sum_p0 = acc_p0 + ACC_W'(adc_data);
    assign avg_p0     = avg_trunc(acc_sum_p0);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        busy        = 1'b0;
        done        = 1'b0;
        adc_req     = 1'b0;
        res_valid   = 1'b0;
        load_settle = 1'b0;
        clr_acc     = 1'b0;
        add_samp    = 1'b0;
        latch_res   = 1'b0;
        ch_inc      = 1'b0;
        ch_clr      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    ch_clr      = 1'b1;
                    clr_acc     = 1'b1;
                    load_settle = 1'b1;
                    state_nxt   = SETTLE;
                end
            end
            SETTLE: begin
                busy = 1'b1;
                if (settle_cnt == '0) state_nxt = REQ;
            end
            REQ: begin
                busy      = 1'b1;
                adc_req   = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (adc_valid) begin
                    add_samp = 1'b1;
                    if (samp_cnt == LAST_SAMP) begin
                        latch_res = 1'b1;
                        state_nxt = EMIT;
                    end else begin
                        state_nxt = REQ;
                    end
                end
            end
            EMIT: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                if (res_ready) begin
                    if (ch_sel == LAST_CH) begin
                        state_nxt = FIN;
                    end else begin
                        ch_inc      = 1'b1;
                        clr_acc     = 1'b1;
                        load_settle = 1'b1;
                        state_nxt   = SETTLE;
                    end
                end
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // stage 0: channel select, settle timing and sample accumulation
`ifdef THRESH_FLAG_EN
    logic [DATA_W-1:0] thresh_q;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            ch_sel     <= '0;
            settle_cnt <= '0;
            samp_cnt   <= '0;
            acc_p0     <= '0;
`ifdef THRESH_FLAG_EN
            thresh_q   <= '0;
`endif
        end else begin
            if (ch_clr)      ch_sel <= '0;
            else if (ch_inc) ch_sel <= ch_sel + 1'b1;

            if (load_settle)
                settle_cnt <= SETTLE_LOAD;
            else if (state == SETTLE && settle_cnt != '0)
                settle_cnt <= settle_cnt - 1'b1;

            if (clr_acc) begin
                acc_p0   <= '0;
                samp_cnt <= '0;
            end else if (add_samp) begin
                acc_p0   <= acc_sum_p0;
                samp_cnt <= samp_cnt + 1'b1;
            end
`ifdef THRESH_FLAG_EN
            if (ch_clr) thresh_q <= thresh;
`endif
        end
    end

    // stage 1: result registers, frozen from EMIT entry until the handshake
`ifdef THRESH_FLAG_EN
    logic hit_p1;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            res_data_p1 <= '0;
            res_ch_p1   <= '0;
`ifdef THRESH_FLAG_EN
            hit_p1      <= 1'b0;
`endif
        end else if (latch_res) begin
            res_data_p1 <= avg_p0;
            res_ch_p1   <= ch_sel;
`ifdef THRESH_FLAG_EN
            hit_p1      <= (avg_p0 >= thresh_q);
`endif
        end
    end

    assign res_data = res_data_p1;
    assign res_ch   = res_ch_p1;
`ifdef THRESH_FLAG_EN
    assign res_hit  = hit_p1 & res_valid;
`endif

endmodule

// File: tb/tb_opt_readout_scanner.sv
`timescale 1ns/1ps
// tb_opt_readout_scanner: directed bench with a bench-side ADC responder (3-cycle latency) and a result logger.
module tb_opt_readout_scanner;
    localparam int DATA_W = 12;

    logic              clk, rst, start, busy, done, adc_req, adc_valid, res_valid, res_ready;
    logic [2:0]        ch_sel, res_ch;
    logic [DATA_W-1:0] adc_data, res_data;
    logic              s_start, s_busy, s_done, s_adc_req, s_adc_valid, s_res_valid, s_res_ready;
    logic [0:0]        s_ch_sel, s_res_ch;
    logic [DATA_W-1:0] s_adc_data, s_res_data;
`ifdef THRESH_FLAG_EN
    logic [DATA_W-1:0] thresh, s_thresh;
    logic              res_hit, s_res_hit;
    int                log_hit[128];
`endif

    int checks, errors;
    int ch_base[8];
    int samp_off[4];
    bit spur_en;
    bit pend;
    int cd, adc_idx;
    logic [DATA_W-1:0] pend_data;
    int cyc, chg_cyc;
    int gap[8];
    bit gap_armed;
    logic [2:0] prev_ch;
    int log_n, done_n;
    int log_ch[128];
    int log_data[128];

    opt_readout_scanner #(.NUM_CH(8), .DATA_W(DATA_W), .LOG2_SAMP(2), .SETTLE_CYC(16)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .ch_sel(ch_sel), .adc_req(adc_req), .adc_valid(adc_valid), .adc_data(adc_data),
`ifdef THRESH_FLAG_EN
        .thresh(thresh), .res_hit(res_hit),
`endif
        .res_valid(res_valid), .res_ready(res_ready), .res_ch(res_ch), .res_data(res_data)
    );

    opt_readout_scanner #(.NUM_CH(2), .DATA_W(DATA_W), .LOG2_SAMP(0), .SETTLE_CYC(1)) dut1 (
        .clk(clk), .rst(rst), .start(s_start), .busy(s_busy), .done(s_done),
        .ch_sel(s_ch_sel), .adc_req(s_adc_req), .adc_valid(s_adc_valid), .adc_data(s_adc_data),
`ifdef THRESH_FLAG_EN
        .thresh(s_thresh), .res_hit(s_res_hit),
`endif
        .res_valid(s_res_valid), .res_ready(s_res_ready), .res_ch(s_res_ch), .res_data(s_res_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ADC model: answers 3 cycles after each request; optional spurious valids while idle
    initial begin
        adc_valid = 1'b0; adc_data = '0; pend = 1'b0; cd = 0; adc_idx = 0; pend_data = '0;
        forever begin
            @(negedge clk);
            adc_valid = 1'b0;
            if (rst === 1'b1) begin
                pend = 1'b0; adc_idx = 0;
            end else begin
                if (pend && cd == 1) begin
                    adc_valid = 1'b1; adc_data = pend_data; pend = 1'b0;
                end else if (pend) begin
                    cd--;
                end else if (spur_en) begin
                    adc_valid = 1'b1; adc_data = 12'hFFF;
                end
                if (adc_req === 1'b1) begin
                    pend = 1'b1; cd = 3;
                    pend_data = DATA_W'(ch_base[ch_sel] + samp_off[adc_idx]);
                    adc_idx = (adc_idx + 1) % 4;
                end
            end
        end
    end

    // Logger: sampled 2ns after the falling edge, after the bench has driven its inputs
    initial begin
        cyc = 0; chg_cyc = 0; gap_armed = 1'b0; prev_ch = '0; log_n = 0; done_n = 0;
        for (int i = 0; i < 8; i++) gap[i] = -1;
        forever begin
            @(negedge clk); #2;
            cyc++;
            if (res_valid === 1'b1 && res_ready === 1'b1 && log_n < 128) begin
                log_ch[log_n]   = int'(res_ch);
                log_data[log_n] = int'(res_data);
`ifdef THRESH_FLAG_EN
                log_hit[log_n]  = int'(res_hit);
`endif
                log_n++;
            end
            if (done === 1'b1) done_n++;
            if (ch_sel !== prev_ch) begin chg_cyc = cyc; gap_armed = 1'b1; end
            if (adc_req === 1'b1 && gap_armed) begin gap[ch_sel] = cyc - chg_cyc; gap_armed = 1'b0; end
            prev_ch = ch_sel;
        end
    end

    task automatic set_pattern(input int base_v, input bit ramp);
        for (int i = 0; i < 8; i++) ch_base[i] = base_v;
        for (int k = 0; k < 4; k++) samp_off[k] = ramp ? 4 * k : 0;
    endtask

    task automatic pulse_start;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin ok = 1'b1; break; end
        end
        #3;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, adc_req, res_valid} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctrl busy/done/req/valid got %b want 0000", {busy, done, adc_req, res_valid});
        end
        checks++;
        if ({ch_sel, res_ch} !== 6'd0) begin
            errors++; $display("FAIL reset_ch ch_sel/res_ch got %0d/%0d want 0/0", ch_sel, res_ch);
        end
        checks++;
        if (res_data !== 12'd0) begin
            errors++; $display("FAIL reset_data got %h want 000", res_data);
        end
        checks++;
        if ({s_busy, s_done, s_adc_req, s_res_valid, s_res_data} !== 16'd0) begin
            errors++; $display("FAIL reset_dut1 got %h want 0000", {s_busy, s_done, s_adc_req, s_res_valid, s_res_data});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, adc_req} !== 2'b00) begin
            errors++; $display("FAIL idle_no_start busy/req got %b want 00", {busy, adc_req});
        end
    endtask

    task automatic test_basic_scan;
        int base, dbase, drops;
        bit ok;
        base = log_n; dbase = done_n; drops = 0; ok = 1'b0;
        set_pattern(100, 1'b1);
        res_ready = 1'b1;
        pulse_start();
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL basic_busy_after_start got %b want 1", busy);
        end
        for (int i = 0; i < 2000; i++) begin
            if (done === 1'b1) begin ok = 1'b1; break; end
            if (busy !== 1'b1) drops++;
            @(negedge clk);
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_done_timeout got no done want done"); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got %b want 0", busy); end
        #3;
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width got %b want 0", done); end
        checks++;
        if (drops != 0) begin errors++; $display("FAIL basic_busy_drops got %0d want 0", drops); end
        checks++;
        if (log_n - base != 8) begin errors++; $display("FAIL basic_result_count got %0d want 8", log_n - base); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (log_ch[base+i] != i || log_data[base+i] != 106) begin
                errors++;
                $display("FAIL basic_result_%0d got ch=%0d data=%0d want ch=%0d data=106", i, log_ch[base+i], log_data[base+i], i);
            end
        end
        checks++;
        if (done_n - dbase != 1) begin errors++; $display("FAIL basic_done_count got %0d want 1", done_n - dbase); end
    endtask

    task automatic test_backpressure;
        int base, dbase;
        bit ok;
        base = log_n; dbase = done_n;
        set_pattern(100, 1'b1);
        res_ready = 1'b1;
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (ch_sel == 3'd3 && res_valid == 1'b0) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        res_ready = 1'b0;
        for (int i = 0; i < 300 && ok; i++) begin
            if (res_valid === 1'b1) break;
            @(negedge clk);
        end
        checks++;
        if (!ok || res_valid !== 1'b1) begin
            errors++; $display("FAIL bp_reach_ch3 got valid=%b ch_sel=%0d want valid=1 ch_sel=3", res_valid, ch_sel);
        end
        for (int k = 0; k < 10; k++) begin
            checks++;
            if ({res_valid, res_ch, res_data, ch_sel, adc_req} !== {1'b1, 3'd3, 12'd106, 3'd3, 1'b0}) begin
                errors++;
                $display("FAIL bp_hold_%0d got valid=%b ch=%0d data=%0d sel=%0d req=%b want 1/3/106/3/0",
                         k, res_valid, res_ch, res_data, ch_sel, adc_req);
            end
            @(negedge clk);
        end
        res_ready = 1'b1;
        wait_done(2000, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL bp_done_timeout got no done want done"); end
        checks++;
        if (log_n - base != 8 || log_ch[base+3] != 3 || log_data[base+3] != 106) begin
            errors++;
            $display("FAIL bp_results got n=%0d ch3=%0d d3=%0d want 8/3/106", log_n - base, log_ch[base+3], log_data[base+3]);
        end
        checks++;
        if (done_n - dbase != 1) begin errors++; $display("FAIL bp_done_count got %0d want 1", done_n - dbase); end
    endtask

    task automatic test_settle_spurious;
        int base;
        bit ok;
        base = log_n;
        set_pattern(0, 1'b0);
        spur_en = 1'b1;
        pulse_start();
        wait_done(2000, ok);
        spur_en = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL settle_done_timeout got no done want done"); end
        for (int c = 0; c < 8; c += 3) begin
            checks++;
            if (gap[c] != 16) begin errors++; $display("FAIL settle_gap_ch%0d got %0d want 16", c, gap[c]); end
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (log_data[base+i] != 0) begin
                errors++; $display("FAIL spurious_data_%0d got %0d want 0", i, log_data[base+i]);
            end
        end
    endtask

    task automatic test_full_scale;
        int base;
        bit ok;
        base = log_n;
        set_pattern(12'hFFF, 1'b0);
        pulse_start();
        wait_done(2000, ok);
        checks++;
        if (!ok || log_n - base != 8) begin
            errors++; $display("FAIL full_done got ok=%0d n=%0d want 1/8", ok, log_n - base);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (log_data[base+i] != 12'hFFF) begin
                errors++; $display("FAIL full_scale_%0d got %h want fff", i, log_data[base+i]);
            end
        end
    endtask

    task automatic test_start_ignored;
        int base, dbase;
        bit ok;
        base = log_n; dbase = done_n;
        set_pattern(100, 1'b1);
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (ch_sel == 3'd2) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        checks++;
        if (!ok || ch_sel !== 3'd2) begin
            errors++; $display("FAIL restart_ch2 got ch_sel=%0d want 2", ch_sel);
        end
        wait_done(2000, ok);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL restart_done_timeout got no done want done"); end
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, adc_req} !== 2'b00) begin
            errors++; $display("FAIL start_in_fin busy/req got %b want 00", {busy, adc_req});
        end
        checks++;
        if (log_n - base != 8 || done_n - dbase != 1) begin
            errors++; $display("FAIL restart_counts got n=%0d done=%0d want 8/1", log_n - base, done_n - dbase);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (log_ch[base+i] != i || log_data[base+i] != 106) begin
                errors++;
                $display("FAIL restart_result_%0d got ch=%0d data=%0d want ch=%0d data=106", i, log_ch[base+i], log_data[base+i], i);
            end
        end
    endtask

    task automatic test_reset_mid_scan;
        int base, dbase;
        bit ok;
        base = log_n; dbase = done_n;
        set_pattern(100, 1'b1);
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk); #1;
            if (ch_sel == 3'd5 && pend && adc_req == 1'b0) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL rst_reach_ch5_wait got ch_sel=%0d want 5", ch_sel); end
        rst = 1'b1;
        @(negedge clk); #1;
        checks++;
        if ({busy, done, adc_req, res_valid} !== 4'b0000) begin
            errors++; $display("FAIL rst_mid_ctrl got %b want 0000", {busy, done, adc_req, res_valid});
        end
        checks++;
        if ({ch_sel, res_ch} !== 6'd0 || res_data !== 12'd0) begin
            errors++; $display("FAIL rst_mid_data got sel=%0d ch=%0d data=%0d want 0/0/0", ch_sel, res_ch, res_data);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (log_n - base != 5 || done_n != dbase || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_abort got n=%0d done=%0d busy=%b want 5/0/0", log_n - base, done_n - dbase, busy);
        end
        pulse_start();
        wait_done(2000, ok);
        checks++;
        if (!ok || log_n - base != 13) begin
            errors++; $display("FAIL rst_rescan got ok=%0d n=%0d want 1/13", ok, log_n - base);
        end
        checks++;
        if (log_ch[base+5] != 0 || log_data[base+5] != 106 || log_ch[base+12] != 7) begin
            errors++;
            $display("FAIL rst_rescan_order got first=%0d/%0d last=%0d want 0/106/7", log_ch[base+5], log_data[base+5], log_ch[base+12]);
        end
        checks++;
        if (done_n - dbase != 1) begin errors++; $display("FAIL rst_done_count got %0d want 1", done_n - dbase); end
    endtask

`ifdef THRESH_FLAG_EN
    task automatic test_thresh_flag;
        int base;
        bit ok;
        int exp_hit[4];
        base = log_n;
        set_pattern(0, 1'b0);
        ch_base[0] = 499; ch_base[1] = 500; ch_base[2] = 501;
        exp_hit[0] = 0; exp_hit[1] = 1; exp_hit[2] = 1; exp_hit[3] = 0;
        thresh = 12'd500;
        pulse_start();
        thresh = 12'd0;
        wait_done(2000, ok);
        checks++;
        if (!ok || log_data[base] != 499) begin
            errors++; $display("FAIL thresh_scan got ok=%0d d0=%0d want 1/499", ok, log_data[base]);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (log_hit[base+i] != exp_hit[i]) begin
                errors++; $display("FAIL thresh_hit_%0d got %0d want %0d", i, log_hit[base+i], exp_hit[i]);
            end
        end
        checks++;
        if (res_hit !== 1'b0) begin errors++; $display("FAIL thresh_hit_idle got %b want 0", res_hit); end
    endtask
`endif

    task automatic test_single_sample;
        logic [DATA_W-1:0] exp_d;
        bit ok;
        s_res_ready = 1'b1;
        @(negedge clk); s_start = 1'b1;
        @(negedge clk); s_start = 1'b0;
        for (int c = 0; c < 2; c++) begin
            exp_d = (c == 0) ? 12'h5A3 : 12'h0A5;
            ok = 1'b0;
            for (int i = 0; i < 50; i++) begin
                if (s_adc_req === 1'b1) begin ok = 1'b1; break; end
                @(negedge clk);
            end
            checks++;
            if (!ok) begin errors++; $display("FAIL single_req_ch%0d got no req want req", c); end
            s_adc_valid = 1'b1; s_adc_data = 12'h111;
            @(negedge clk); s_adc_data = exp_d;
            @(negedge clk); s_adc_valid = 1'b0;
            checks++;
            if ({s_res_valid, s_res_ch, s_res_data} !== {1'b1, 1'(c), exp_d}) begin
                errors++;
                $display("FAIL single_sample_ch%0d got valid=%b ch=%0d data=%h want 1/%0d/%h", c, s_res_valid, s_res_ch, s_res_data, c, exp_d);
            end
            @(negedge clk);
        end
        checks++;
        if ({s_done, s_busy} !== 2'b10) begin
            errors++; $display("FAIL single_done done/busy got %b want 10", {s_done, s_busy});
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; start = 1'b0; res_ready = 1'b1; spur_en = 1'b0;
        s_start = 1'b0; s_adc_valid = 1'b0; s_adc_data = '0; s_res_ready = 1'b1;
`ifdef THRESH_FLAG_EN
        thresh = '0; s_thresh = '0;
`endif
        set_pattern(0, 1'b0);
        test_reset();
        test_basic_scan();
        test_backpressure();
        test_settle_spurious();
        test_full_scale();
        test_start_ignored();
        test_reset_mid_scan();
`ifdef THRESH_FLAG_EN
        test_thresh_flag();
`endif
        test_single_sample();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
